// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory port.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    FAULT
  } lsu_state_e;

  typedef enum logic [1:0] {
    OK       = 2'b00,
    MISALIGN = 2'b01,
    ILLEGAL  = 2'b10,
    TIMEOUT  = 2'b11
  } lsu_fault_e;

  localparam logic [1:0] NBYTE_WORD = 2'b00;
  localparam logic [1:0] NBYTE_BYTE = 2'b01;
  localparam logic [1:0] NBYTE_HALF = 2'b10;
  localparam logic [1:0] NBYTE_ILL  = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] nbyte_op, input logic [1:0] offset);
    return ((nbyte_op == NBYTE_HALF) && offset[0]) ||
           ((nbyte_op == NBYTE_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  nbyte_op,
  input  logic        is_write,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Word accesses are always aligned when they reach the bus, so shifted equals rdata_in there.
  assign shifted = rdata_in >> {offset, 3'b000};

  always_comb begin
    wstrb      = '0;
    wdata_lane = '0;
    rdata_ext  = shifted;
    case (nbyte_op)
      NBYTE_BYTE: begin
        wstrb      = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      NBYTE_HALF: begin
        wstrb      = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      NBYTE_WORD: begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
    if (!is_write) wstrb = '0;
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: access FSM, input latches and response timeout.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  nbyte_op,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rsp,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  lsu_state_e  state_q, state_d;
  lsu_fault_e  fault_q, fault_d;
  lsu_fault_e  err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  nbyte_q, nbyte_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;

  logic [3:0]  strb;
  logic [31:0] lane;
  logic [31:0] ext;
  logic        in_req;
  logic        rsp_hit;
  logic        cnt_last;

  lsu_align u_align (
    .nbyte_op   (nbyte_q),
    .is_write   (we_q),
    .is_unsigned(uns_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata_in   (bus_rdata),
    .wstrb      (strb),
    .wdata_lane (lane),
    .rdata_ext  (ext)
  );

  assign in_req   = (state_q == REQ);
  assign rsp_hit  = (in_req && bus_gnt && bus_rsp) || ((state_q == RSP) && bus_rsp);
  assign cnt_last = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nbyte_d = nbyte_q;
    we_d    = we_q;
    uns_d   = uns_q;
    case (state_q)
      IDLE: begin
        if (start && (mem_read || mem_write)) begin
          addr_d  = addr;
          wdata_d = wdata;
          nbyte_d = nbyte_op;
          we_d    = mem_write;
          uns_d   = is_unsigned;
          if ((mem_read && mem_write) || (nbyte_op == NBYTE_ILL)) begin
            state_d = FAULT;
            err_d   = ILLEGAL;
          end else if (is_misaligned(nbyte_op, addr[1:0])) begin
            state_d = FAULT;
            err_d   = MISALIGN;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ, RSP: begin
        cnt_d = cnt_q + CW'(1);
        // A response always wins over an expiring timeout in the same cycle.
        if (rsp_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          fault_d = OK;
          if (!we_q) rdata_d = ext;
        end else if (cnt_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          fault_d = TIMEOUT;
        end else if (in_req && bus_gnt) begin
          state_d = RSP;
        end
      end
      FAULT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        fault_d = err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fault_q <= OK;
      err_q   <= OK;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      nbyte_q <= NBYTE_WORD;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      nbyte_q <= nbyte_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign fault     = fault_q;
  assign bus_req   = in_req;
  assign bus_we    = in_req & we_q;
  assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_wstrb = in_req ? strb : '0;
  assign bus_wdata = in_req ? lane : '0;

endmodule
